nios_led_nios2_gen2_0_cpu_ocimem_arbiter: RTL and testbench
===========================================================

# nios_led_nios2_gen2_0_cpu_ocimem_arbiter

Sysclk-domain sequencer and arbiter for the Nios II on-chip debug (OCI) memory: a single-port RAM shared between the JTAG debug slave and the CPU's debug-mode Avalon slave. It decodes the debug slave's `take_*_ocimem_*` strobes and `jdo` payload into JTAG read and write commands, with address auto-increment. It queues one JTAG command, round-robin arbitrates it against CPU accesses, drives the RAM port, and returns read data through `MonDReg` (JTAG) or `avs_readdata` (CPU).

## Interface
- `ADDR_W`, default 8: OCI RAM word-address width; depth is 2^ADDR_W words of 32 bits.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `jdo`  in  38  debug-slave command payload; valid in the cycle of a strobe.
- `take_action_ocimem_a`  in  1  load JTAG address: `MonAReg <= jdo[17 +: ADDR_W]`; if `jdo[35]`=1, also queue a JTAG read.
- `take_action_ocimem_b`  in  1  queue a JTAG write of `jdo[34:3]` at `MonAReg`.
- `take_no_action_ocimem_a`  in  1  queue a JTAG read at `MonAReg`.
- `avs_address`  in  ADDR_W  CPU word address.
- `avs_read`, `avs_write`  in  1  CPU request; held by the master until `avs_waitrequest`=0.
- `avs_writedata`  in  32  CPU write data.
- `avs_readdata`  out  32  equals `ram_rdata`; valid only in the read completion cycle.
- `avs_waitrequest`  out  1  `(avs_read|avs_write) & ~cpu_done`.
- `ram_addr`  out  ADDR_W  registered RAM address.
- `ram_we`  out  1  registered RAM write enable.
- `ram_wdata`  out  32  registered RAM write data.
- `ram_rdata`  in  32  RAM read data; 1-cycle latency from `ram_addr`.
- `MonDReg`  out  32  last JTAG read or write data.
- `MonAReg`  out  ADDR_W  current JTAG address.
- `jtag_busy`  out  1  a JTAG command is pending or in flight.
- `jtag_ovf`  out  1  sticky: a strobe was dropped.

## Operation
- **States:** IDLE, ACCESS, RDWAIT.
- **IDLE**
  - Requesters are `jtag_pend` and CPU (`avs_read|avs_write`).
  - With no request, stay in IDLE.
  - Otherwise pick a winner, register `ram_addr`/`ram_wdata`, set `ram_we`=1 for a write, record owner and op, and go to ACCESS.
- **Arbitration**
  - Round-robin on `rr_last` (0=CPU, 1=JTAG); the requester not equal to `rr_last` wins a tie.
  - `rr_last` updates to the owner on each grant.
- **ACCESS**
  - Write: RAM written this cycle; completion cycle. `ram_we` clears next cycle; go to IDLE.
  - Read: go to RDWAIT.
- **RDWAIT:** `ram_rdata` valid; completion cycle; go to IDLE.
- **Completion, CPU owner:** `cpu_done`=1 (`avs_waitrequest`=0) for exactly that cycle.
- **Completion, JTAG owner**
  - `MonDReg <= ram_rdata` for a read, or the written data for a write.
  - `MonAReg <= MonAReg+1`, wrapping modulo 2^ADDR_W.
  - Clear `jtag_pend`.
- **JTAG strobes**
  - Honoured only when `jtag_busy`=0.
  - If strobes coincide, priority is `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`; the rest are dropped and `jtag_ovf` sets.
  - A strobe while `jtag_busy`=1 is dropped entirely (no address load) and `jtag_ovf` sets.
- **Reset**
  - All outputs and registers clear to 0, including `rr_last`=0.
  - Reset mid-operation abandons any in-flight access; no completion is signalled; `ram_we`=0 in the next cycle.

## Timing
- **Uncontended CPU write** asserted at cycle 0: ACCESS in cycle 1 with `avs_waitrequest`=0.
- **Uncontended CPU read:** `avs_waitrequest`=0 with data in cycle 2.
- **JTAG latency** from strobe at cycle 0:
  - `jtag_pend` set at cycle 1.
  - Earliest ACCESS at cycle 2.
  - Read: `MonDReg`/`MonAReg` update at the cycle-3 edge (visible cycle 4); `jtag_busy`=0 at cycle 4.
  - Write: updates visible at cycle 3.
- **Back-to-back:** at least one IDLE cycle between accesses. Throughput is one write per 2 cycles or one read per 3 cycles.
- **Fairness:** a losing requester is granted at the next IDLE; worst-case wait is one foreign access.

## Test plan
- **JTAG write then read.**
  - Stimulus: `take_action_ocimem_a` with address 0x10, `jdo[35]`=0; then `take_action_ocimem_b` with data 0xDEADBEEF; then `take_action_ocimem_a` with address 0x10, `jdo[35]`=1.
  - Required: RAM[0x10]=0xDEADBEEF, `MonDReg`=0xDEADBEEF, `MonAReg`=0x11.
- **Wrap.**
  - Stimulus: `MonAReg`=0xFF, then `take_no_action_ocimem_a`.
  - Required: `MonAReg`=0x00 after completion.
- **CPU read latency.**
  - Stimulus: RAM[5]=0x12345678, `avs_read` at address 5, idle arbiter.
  - Required: `avs_waitrequest` 1,1,0 over cycles 0-2; `avs_readdata`=0x12345678 in cycle 2.
- **Tie after reset.**
  - Stimulus: CPU write and pending JTAG read reach IDLE simultaneously, first tie after reset.
  - Required: JTAG granted first, CPU granted next; CPU `avs_waitrequest` low in cycle 5.
- **Overflow.**
  - Stimulus: second `take_action_ocimem_b` while `jtag_busy`=1.
  - Required: second write absent from RAM; `jtag_ovf`=1 and stays set.
- **Reset during access.**
  - Stimulus: `reset` asserted in RDWAIT of a JTAG read.
  - Required: `MonDReg`=0, `jtag_busy`=0, `ram_we`=0 the next cycle, no `MonAReg` increment.

Source files
------------

// File: rtl/nios_led_nios2_gen2_0_cpu_ocimem_arbiter.sv
// OCI debug RAM sequencer: decodes JTAG debug-slave strobes into one queued command and
// round-robin arbitrates it against CPU Avalon accesses onto a single-port RAM.
module nios_led_nios2_gen2_0_cpu_ocimem_arbiter #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              jtag_busy,
  output logic              jtag_ovf
);

  typedef enum logic [1:0] {StIdle, StAccess, StRdWait} state_e;

  state_e              state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic                own_jtag_q, own_jtag_d;
  logic                op_wr_q, op_wr_d;
  logic                jtag_pend_q, jtag_pend_d;
  logic                jtag_wr_q, jtag_wr_d;
  logic [31:0]         jtag_wdata_q, jtag_wdata_d;
  logic [ADDR_W-1:0]   mon_a_q, mon_a_d;
  logic [31:0]         mon_d_q, mon_d_d;
  logic                ovf_q, ovf_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [31:0]         ram_wdata_q, ram_wdata_d;

  logic cpu_req;
  logic grant_jtag;
  logic complete;
  logic cpu_done;
  logic jtag_done;
  logic any_strobe;
  logic multi_strobe;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign cpu_req    = avs_read | avs_write;
  // Tie goes to whichever requester was not granted last.
  assign grant_jtag = jtag_pend_q & (~cpu_req | ~rr_last_q);
  assign complete   = ((state_q == StAccess) & op_wr_q) | (state_q == StRdWait);
  // A reset cycle abandons the access, so it never reports completion.
  assign cpu_done   = complete & ~own_jtag_q & ~reset;
  assign jtag_done  = complete & own_jtag_q;

  assign any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                        (take_action_ocimem_a & take_no_action_ocimem_a) |
                        (take_action_ocimem_b & take_no_action_ocimem_a);

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    own_jtag_d   = own_jtag_q;
    op_wr_d      = op_wr_q;
    jtag_pend_d  = jtag_pend_q;
    jtag_wr_d    = jtag_wr_q;
    jtag_wdata_d = jtag_wdata_q;
    mon_a_d      = mon_a_q;
    mon_d_d      = mon_d_q;
    ovf_d        = ovf_q;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = 1'b0;
    ram_wdata_d  = ram_wdata_q;

    case (state_q)
      StIdle: begin
        if (cpu_req | jtag_pend_q) begin
          state_d    = StAccess;
          rr_last_d  = grant_jtag;
          own_jtag_d = grant_jtag;
          if (grant_jtag) begin
            ram_addr_d  = mon_a_q;
            op_wr_d     = jtag_wr_q;
            ram_wdata_d = jtag_wdata_q;
          end else begin
            ram_addr_d  = avs_address;
            op_wr_d     = avs_write;
            ram_wdata_d = avs_writedata;
          end
          ram_we_d = op_wr_d;
        end
      end
      StAccess: state_d = op_wr_q ? StIdle : StRdWait;
      StRdWait: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (jtag_done) begin
      mon_d_d     = op_wr_q ? ram_wdata_q : ram_rdata;
      mon_a_d     = mon_a_q + 1'b1;
      jtag_pend_d = 1'b0;
    end

    // Strobes are only honoured with nothing queued; jtag_done implies a queue, so no overlap.
    if (!jtag_pend_q) begin
      if (take_action_ocimem_a) begin
        mon_a_d = jdo[17 +: ADDR_W];
        if (jdo[35]) begin
          jtag_pend_d = 1'b1;
          jtag_wr_d   = 1'b0;
        end
      end else if (take_action_ocimem_b) begin
        jtag_pend_d  = 1'b1;
        jtag_wr_d    = 1'b1;
        jtag_wdata_d = jdo[34:3];
      end else if (take_no_action_ocimem_a) begin
        jtag_pend_d = 1'b1;
        jtag_wr_d   = 1'b0;
      end
      if (multi_strobe) begin
        ovf_d = 1'b1;
      end
    end else if (any_strobe) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rr_last_q    <= 1'b0;
      own_jtag_q   <= 1'b0;
      op_wr_q      <= 1'b0;
      jtag_pend_q  <= 1'b0;
      jtag_wr_q    <= 1'b0;
      jtag_wdata_q <= '0;
      mon_a_q      <= '0;
      mon_d_q      <= '0;
      ovf_q        <= 1'b0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      own_jtag_q   <= own_jtag_d;
      op_wr_q      <= op_wr_d;
      jtag_pend_q  <= jtag_pend_d;
      jtag_wr_q    <= jtag_wr_d;
      jtag_wdata_q <= jtag_wdata_d;
      mon_a_q      <= mon_a_d;
      mon_d_q      <= mon_d_d;
      ovf_q        <= ovf_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  assign avs_readdata    = ram_rdata;
  assign avs_waitrequest = cpu_req & ~cpu_done;
  assign ram_addr        = ram_addr_q;
  assign ram_we          = ram_we_q;
  assign ram_wdata       = ram_wdata_q;
  assign MonDReg         = mon_d_q;
  assign MonAReg         = mon_a_q;
  assign jtag_busy       = jtag_pend_q;
  assign jtag_ovf        = ovf_q;

endmodule

// File: tb/tb_nios_led_nios2_gen2_0_cpu_ocimem_arbiter.sv
// Bench for the OCI RAM arbiter: directed test-plan steps, then random JTAG/CPU traffic
// checked against a word-level model of RAM contents and the JTAG monitor registers.
module tb_nios_led_nios2_gen2_0_cpu_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] MonDReg;
  logic [7:0]  MonAReg;
  logic        jtag_busy, jtag_ovf;

  always #5 clk = ~clk;

  nios_led_nios2_gen2_0_cpu_ocimem_arbiter #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .MonDReg(MonDReg), .MonAReg(MonAReg), .jtag_busy(jtag_busy), .jtag_ovf(jtag_ovf)
  );

  // Synchronous single-port RAM with a preload port used only during reset.
  logic [31:0] ram [0:255];
  logic        pl_we;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  logic [31:0] mem_m [0:255];
  logic [7:0]  mona_m;
  logic [31:0] mond_m;
  logic        ovf_m;
  int total = 0;
  int bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind 0: address load (rd queues a read), 1: write data, 2: read at MonAReg
  task automatic strobe(input int kind, input logic [7:0] addr, input logic rd,
                        input logic [31:0] data);
    jdo = '0;
    if (kind == 0) begin
      jdo[24:17] = addr;
      jdo[35] = rd;
      take_action_ocimem_a = 1'b1;
    end else if (kind == 1) begin
      jdo[34:3] = data;
      take_action_ocimem_b = 1'b1;
    end else begin
      take_no_action_ocimem_a = 1'b1;
    end
    step();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    jdo = '0;
  endtask

  task automatic wait_jtag(input string tag);
    int n = 0;
    while (jtag_busy !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    chk({tag, " busy clear"}, {31'b0, jtag_busy}, 32'd0);
  endtask

  task automatic check_mon(input string tag);
    chk({tag, " MonAReg"}, {24'b0, MonAReg}, {24'b0, mona_m});
    chk({tag, " MonDReg"}, MonDReg, mond_m);
  endtask

  task automatic model_jrd();
    mond_m = mem_m[mona_m];
    mona_m = mona_m + 8'd1;
  endtask

  task automatic model_jwr(input logic [31:0] d);
    mem_m[mona_m] = d;
    mond_m = d;
    mona_m = mona_m + 8'd1;
  endtask

  task automatic cpu_access(input logic wr, input logic [7:0] a, input logic [31:0] d,
                            output logic [31:0] rd);
    int n = 0;
    avs_address = a;
    avs_write = wr;
    avs_read = ~wr;
    avs_writedata = d;
    step();
    while (avs_waitrequest && n < 20) begin
      step();
      n++;
    end
    chk("cpu waitrequest released", {31'b0, avs_waitrequest}, 32'd0);
    rd = avs_readdata;
    step();
    avs_read = 1'b0;
    avs_write = 1'b0;
  endtask

  initial begin
    logic [31:0] rdv, d, cd;
    logic [7:0]  a, c;
    int          op, dly, k, mm;
    bit          cpu_on, cpu_fin;

    reset = 1'b1;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    avs_address = '0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    pl_we = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    step();
    for (int i = 0; i < 256; i++) begin
      pl_we = 1'b1;
      pl_addr = 8'(i);
      pl_data = $urandom;
      mem_m[i] = pl_data;
      step();
    end
    pl_we = 1'b0;
    step();

    chk("reset MonDReg", MonDReg, 32'd0);
    chk("reset MonAReg", {24'b0, MonAReg}, 32'd0);
    chk("reset jtag_busy", {31'b0, jtag_busy}, 32'd0);
    chk("reset jtag_ovf", {31'b0, jtag_ovf}, 32'd0);
    chk("reset ram_we", {31'b0, ram_we}, 32'd0);
    chk("reset ram_addr", {24'b0, ram_addr}, 32'd0);
    chk("reset ram_wdata", ram_wdata, 32'd0);
    reset = 1'b0;
    mona_m = '0;
    mond_m = '0;
    ovf_m = 1'b0;
    step();

    // JTAG write then read back at 0x10
    strobe(0, 8'h10, 1'b0, '0);
    mona_m = 8'h10;
    chk("t1 address load", {24'b0, MonAReg}, 32'h10);
    chk("t1 load not busy", {31'b0, jtag_busy}, 32'd0);
    jdo = '0;
    jdo[34:3] = 32'hDEADBEEF;
    take_action_ocimem_b = 1'b1;
    step();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    chk("t1 write busy c1", {31'b0, jtag_busy}, 32'd1);
    step();
    chk("t1 ram_we c2", {31'b0, ram_we}, 32'd1);
    chk("t1 ram_addr c2", {24'b0, ram_addr}, 32'h10);
    chk("t1 ram_wdata c2", ram_wdata, 32'hDEADBEEF);
    step();
    model_jwr(32'hDEADBEEF);
    check_mon("t1 write c3");
    chk("t1 write idle c3", {31'b0, jtag_busy}, 32'd0);
    strobe(0, 8'h10, 1'b1, '0);
    mona_m = 8'h10;
    step();
    step();
    chk("t1 read busy c3", {31'b0, jtag_busy}, 32'd1);
    step();
    model_jrd();
    check_mon("t1 read c4");
    chk("t1 read idle c4", {31'b0, jtag_busy}, 32'd0);
    chk("t1 ram[0x10]", ram[16], 32'hDEADBEEF);

    // Address wrap
    strobe(0, 8'hFF, 1'b0, '0);
    mona_m = 8'hFF;
    strobe(2, '0, 1'b0, '0);
    step();
    step();
    step();
    model_jrd();
    check_mon("wrap");

    // CPU read latency
    strobe(0, 8'h05, 1'b0, '0);
    mona_m = 8'h05;
    strobe(1, '0, 1'b0, 32'h12345678);
    wait_jtag("preload 5");
    model_jwr(32'h12345678);
    avs_address = 8'h05;
    avs_read = 1'b1;
    #1;
    chk("cpu rd waitreq c0", {31'b0, avs_waitrequest}, 32'd1);
    step();
    chk("cpu rd waitreq c1", {31'b0, avs_waitrequest}, 32'd1);
    step();
    chk("cpu rd waitreq c2", {31'b0, avs_waitrequest}, 32'd0);
    chk("cpu rd data c2", avs_readdata, 32'h12345678);
    step();
    avs_read = 1'b0;

    // First tie after reset goes to JTAG
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    mona_m = '0;
    mond_m = '0;
    step();
    strobe(0, 8'h30, 1'b0, '0);
    mona_m = 8'h30;
    take_no_action_ocimem_a = 1'b1;
    step();
    take_no_action_ocimem_a = 1'b0;
    avs_address = 8'h20;
    avs_writedata = 32'hCAFEF00D;
    avs_write = 1'b1;
    #1;
    chk("tie waitreq c1", {31'b0, avs_waitrequest}, 32'd1);
    step();
    chk("tie jtag granted first", {24'b0, ram_addr}, 32'h30);
    chk("tie waitreq c2", {31'b0, avs_waitrequest}, 32'd1);
    step();
    chk("tie waitreq c3", {31'b0, avs_waitrequest}, 32'd1);
    step();
    chk("tie waitreq c4", {31'b0, avs_waitrequest}, 32'd1);
    model_jrd();
    check_mon("tie jtag done c4");
    step();
    chk("tie waitreq c5", {31'b0, avs_waitrequest}, 32'd0);
    chk("tie cpu ram_we c5", {31'b0, ram_we}, 32'd1);
    chk("tie cpu ram_addr c5", {24'b0, ram_addr}, 32'h20);
    step();
    avs_write = 1'b0;
    mem_m[8'h20] = 32'hCAFEF00D;
    step();
    chk("tie ram[0x20]", ram[32], 32'hCAFEF00D);

    // Strobe while busy is dropped
    strobe(0, 8'h40, 1'b0, '0);
    mona_m = 8'h40;
    jdo = '0;
    jdo[34:3] = 32'hAAAA5555;
    take_action_ocimem_b = 1'b1;
    step();
    jdo[34:3] = 32'h0BADF00D;
    chk("ovf busy c1", {31'b0, jtag_busy}, 32'd1);
    step();
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    chk("ovf set", {31'b0, jtag_ovf}, 32'd1);
    wait_jtag("ovf");
    model_jwr(32'hAAAA5555);
    check_mon("ovf");
    step();
    step();
    step();
    chk("ovf ram[0x40]", ram[64], 32'hAAAA5555);
    chk("ovf ram[0x41] untouched", ram[65], mem_m[65]);
    chk("ovf sticky", {31'b0, jtag_ovf}, 32'd1);

    // Reset in RDWAIT of a JTAG read
    strobe(0, 8'h50, 1'b0, '0);
    take_no_action_ocimem_a = 1'b1;
    step();
    take_no_action_ocimem_a = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("rst mid MonDReg", MonDReg, 32'd0);
    chk("rst mid MonAReg", {24'b0, MonAReg}, 32'd0);
    chk("rst mid jtag_busy", {31'b0, jtag_busy}, 32'd0);
    chk("rst mid ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst mid jtag_ovf", {31'b0, jtag_ovf}, 32'd0);
    reset = 1'b0;
    mona_m = '0;
    mond_m = '0;
    step();

    // Coincident strobes: address load wins, write dropped
    jdo = '0;
    jdo[24:17] = 8'h60;
    take_action_ocimem_a = 1'b1;
    take_action_ocimem_b = 1'b1;
    step();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    jdo = '0;
    mona_m = 8'h60;
    ovf_m = 1'b1;
    chk("coincide MonAReg", {24'b0, MonAReg}, 32'h60);
    chk("coincide not busy", {31'b0, jtag_busy}, 32'd0);
    chk("coincide ovf", {31'b0, jtag_ovf}, 32'd1);

    // Random traffic
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 5);
      a = 8'($urandom);
      d = $urandom;
      case (op)
        0: begin
          strobe(0, a, 1'b1, '0);
          wait_jtag("rnd load+read");
          mona_m = a;
          model_jrd();
          check_mon("rnd load+read");
        end
        1: begin
          strobe(1, '0, 1'b0, d);
          wait_jtag("rnd write");
          model_jwr(d);
          check_mon("rnd write");
        end
        2: begin
          strobe(2, '0, 1'b0, '0);
          wait_jtag("rnd read");
          model_jrd();
          check_mon("rnd read");
        end
        3: begin
          cpu_access(1'b1, a, d, rdv);
          mem_m[a] = d;
        end
        4: begin
          cpu_access(1'b0, a, '0, rdv);
          chk("rnd cpu read", rdv, mem_m[a]);
        end
        default: begin
          // JTAG write racing a CPU write to a different address
          c = mona_m + 8'(1 + $urandom_range(0, 200));
          cd = $urandom;
          dly = $urandom_range(0, 2);
          jdo = '0;
          jdo[34:3] = d;
          take_action_ocimem_b = 1'b1;
          cpu_on = 1'b0;
          cpu_fin = 1'b0;
          if (dly == 0) begin
            avs_address = c;
            avs_writedata = cd;
            avs_write = 1'b1;
            cpu_on = 1'b1;
          end
          step();
          take_action_ocimem_b = 1'b0;
          jdo = '0;
          k = 0;
          while (!(cpu_fin && !jtag_busy) && k < 40) begin
            if (!cpu_on && !cpu_fin && k + 1 >= dly) begin
              avs_address = c;
              avs_writedata = cd;
              avs_write = 1'b1;
              cpu_on = 1'b1;
            end
            step();
            k++;
            if (cpu_on && !avs_waitrequest) begin
              step();
              avs_write = 1'b0;
              cpu_on = 1'b0;
              cpu_fin = 1'b1;
              k++;
            end
          end
          chk("rnd race both done", {30'b0, cpu_fin, jtag_busy}, 32'd2);
          model_jwr(d);
          mem_m[c] = cd;
          check_mon("rnd race");
        end
      endcase
    end

    step();
    step();
    mm = 0;
    for (int i = 0; i < 256; i++) begin
      if (ram[i] !== mem_m[i]) mm++;
    end
    chk("final ram mismatches", mm, 32'd0);
    chk("final jtag_ovf", {31'b0, jtag_ovf}, {31'b0, ovf_m});
    check_mon("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
